// File: rtl/matrix_addsub_stream.sv
// Streaming element-wise add/subtract of two N x N signed matrices, LANES
// elements per beat, with wrap or saturate arithmetic and a 2-stage pipeline.
module matrix_addsub_stream #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int LANES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*2*WIDTH-1:0]  in_a,
  input  logic [LANES*2*WIDTH-1:0]  in_b,
  input  logic [1:0]                mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*2*WIDTH-1:0]  out_c,
  output logic [LANES-1:0]          out_ovf,
  output logic                      out_last,
  output logic [15:0]               mat_count,
  output logic                      busy
);

  localparam int EW    = 2 * WIDTH;
  localparam int BEATS = (N * N) / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [EW-1:0] SAT_MAX   = {1'b0, {(EW-1){1'b1}}};
  localparam logic [EW-1:0] SAT_MIN   = {1'b1, {(EW-1){1'b0}}};

  logic                   s1_valid;
  logic [LANES*EW-1:0]    s1_a;
  logic [LANES*EW-1:0]    s1_b;
  logic [1:0]             s1_mode;
  logic                   s2_valid;
  logic [LANES*EW-1:0]    s2_c;
  logic [LANES-1:0]       s2_ovf;
  logic [CW-1:0]          in_cnt;
  logic [CW-1:0]          out_cnt;
  logic [1:0]             mode_lat;
  logic [15:0]            mat_cnt;

  logic                   s2_adv;
  logic                   in_fire;
  logic                   out_fire;
  logic [1:0]             eff_mode;
  logic [LANES*EW-1:0]    res_c;
  logic [LANES-1:0]       res_ovf;
  logic [EW-1:0]          op_a;
  logic [EW-1:0]          op_b;
  logic [EW-1:0]          raw;
  logic                   ov;

  // Handshake and stage-advance control; outputs are forced quiet while rst is high.
  always_comb begin
    s2_adv    = !s2_valid || out_ready;
    in_ready  = !rst && (!s1_valid || s2_adv);
    in_fire   = in_valid && in_ready;
    out_valid = !rst && s2_valid;
    out_fire  = out_valid && out_ready;
    out_c     = rst ? '0 : s2_c;
    out_ovf   = rst ? '0 : s2_ovf;
    out_last  = out_valid && (out_cnt == LAST_BEAT);
    mat_count = rst ? '0 : mat_cnt;
    busy      = !rst && ((in_cnt != '0) || s1_valid || s2_valid);
    // Beat 0 uses the live mode; later beats reuse the value captured with beat 0.
    eff_mode  = (in_cnt == '0) ? mode : mode_lat;
  end

  // Per-lane arithmetic on the S1 operands, with signed overflow detection and clamping.
  always_comb begin
    res_c   = '0;
    res_ovf = '0;
    op_a    = '0;
    op_b    = '0;
    raw     = '0;
    ov      = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      op_a = s1_a[i*EW +: EW];
      op_b = s1_b[i*EW +: EW];
      if (s1_mode[0]) begin
        raw = op_a - op_b;
        ov  = (op_a[EW-1] != op_b[EW-1]) && (raw[EW-1] != op_a[EW-1]);
      end else begin
        raw = op_a + op_b;
        ov  = (op_a[EW-1] == op_b[EW-1]) && (raw[EW-1] != op_a[EW-1]);
      end
      if (s1_mode[1] && ov) begin
        res_c[i*EW +: EW] = op_a[EW-1] ? SAT_MIN : SAT_MAX;
      end else begin
        res_c[i*EW +: EW] = raw;
      end
      res_ovf[i] = ov;
    end
  end

  // Stage 1: capture operands and effective mode on an input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= '0;
    end else if (!s1_valid || s2_adv) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_mode <= eff_mode;
      end
    end
  end

  // Stage 2: register the result; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_c     <= '0;
      s2_ovf   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_c   <= res_c;
        s2_ovf <= res_ovf;
      end
    end
  end

  // Input beat counter and per-matrix mode latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt   <= '0;
      mode_lat <= 2'b00;
    end else if (in_fire) begin
      if (in_cnt == '0) mode_lat <= mode;
      in_cnt <= (in_cnt == LAST_BEAT) ? '0 : in_cnt + 1'b1;
    end
  end

  // Output beat counter and completed-matrix counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
      mat_cnt <= '0;
    end else if (out_fire) begin
      out_cnt <= (out_cnt == LAST_BEAT) ? '0 : out_cnt + 1'b1;
      if (out_cnt == LAST_BEAT) mat_cnt <= mat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_matrix_addsub_stream.sv
// Directed bench for matrix_addsub_stream at N=4, LANES=4, EW=32.
module tb_matrix_addsub_stream;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_a;
  logic [127:0]  in_b;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_c;
  logic [3:0]    out_ovf;
  logic          out_last;
  logic [15:0]   mat_count;
  logic          busy;

  int            vectors = 0;
  int            miscompares = 0;
  logic [15:0]   exp_mat = '0;

  matrix_addsub_stream #(.WIDTH(16), .N(4), .LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_c(out_c), .out_ovf(out_ovf),
    .out_last(out_last), .mat_count(mat_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rep(input logic [31:0] x);
    return {x, x, x, x};
  endfunction

  function automatic logic [127:0] pack4(input logic [31:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Four back-to-back beats of identical data with out_ready held high;
  // beats 0-1 are driven with m_first and beats 2-3 with m_second.
  task automatic send_matrix(input string tag, input logic [1:0] m_first, input logic [1:0] m_second,
                             input logic [127:0] a, input logic [127:0] b,
                             input logic [127:0] expc, input logic [3:0] expo);
    out_ready = 1'b1;
    in_a = a;
    in_b = b;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = (cyc < 4);
      mode = (cyc < 2) ? m_first : m_second;
      #1;
      if (cyc < 4) check({tag, " in_ready"}, 128'(in_ready), 128'(1'b1));
      tick();
      if (cyc == 0 || cyc == 5) begin
        check({tag, " out_valid idle"}, 128'(out_valid), 128'(1'b0));
      end else begin
        check({tag, " out_valid"}, 128'(out_valid), 128'(1'b1));
        check({tag, " out_c"}, out_c, expc);
        check({tag, " out_ovf"}, 128'(out_ovf), 128'(expo));
        check({tag, " out_last"}, 128'(out_last), 128'(cyc == 4));
      end
    end
    in_valid = 1'b0;
    exp_mat++;
    check({tag, " mat_count"}, 128'(mat_count), 128'(exp_mat));
    check({tag, " busy"}, 128'(busy), 128'(1'b0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; mode = 2'b00; out_ready = 1'b0;
    #1;
    check("rst in_ready", 128'(in_ready), 128'(1'b0));
    check("rst out_valid", 128'(out_valid), 128'(1'b0));
    tick();
    tick();
    check("rst out_c", out_c, '0);
    check("rst out_ovf", 128'(out_ovf), '0);
    check("rst out_last", 128'(out_last), '0);
    check("rst busy", 128'(busy), '0);
    check("rst mat_count", 128'(mat_count), '0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", 128'(in_ready), 128'(1'b1));

    // Basic add: 5+7 = 12 in every lane, last on 4th output.
    send_matrix("add", 2'b00, 2'b00, rep(32'd5), rep(32'd7), rep(32'd12), 4'b0000);

    // Saturating and wrapping add with mixed per-lane overflow.
    send_matrix("addsat", 2'b10, 2'b10,
                pack4(32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'h7FFFFFF0),
                pack4(32'h00000001, 32'hFFFFFFFF, 32'h00000002, 32'h00000020),
                pack4(32'h00000000, 32'h80000000, 32'h00000003, 32'h7FFFFFFF), 4'b0101);
    send_matrix("addwrap", 2'b00, 2'b00,
                pack4(32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'h7FFFFFF0),
                pack4(32'h00000001, 32'hFFFFFFFF, 32'h00000002, 32'h00000020),
                pack4(32'h00000000, 32'h7FFFFFFF, 32'h00000003, 32'h80000010), 4'b0101);

    // Saturating and wrapping subtract.
    send_matrix("subsat", 2'b11, 2'b11,
                pack4(32'h00000000, 32'h7FFFFFFF, 32'h00000003, 32'h80000000),
                pack4(32'h80000000, 32'hFFFFFFFF, 32'h00000005, 32'h00000001),
                pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h80000000), 4'b1101);
    send_matrix("subwrap", 2'b01, 2'b01,
                pack4(32'h00000000, 32'h7FFFFFFF, 32'h00000003, 32'h80000000),
                pack4(32'h80000000, 32'hFFFFFFFF, 32'h00000005, 32'h00000001),
                pack4(32'h80000000, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF), 4'b1101);

    // Mode change mid-matrix is ignored; the next matrix picks it up.
    send_matrix("modeswitch", 2'b00, 2'b01, rep(32'd5), rep(32'd7), rep(32'd12), 4'b0000);
    send_matrix("nextsub", 2'b01, 2'b01, rep(32'd5), rep(32'd7), rep(32'hFFFFFFFE), 4'b0000);

    // Backpressure: out_ready low while input keeps streaming; beat k carries A=100+k, B=1.
    mode = 2'b00; in_b = rep(32'd1); out_ready = 1'b0;
    in_valid = 1'b1; in_a = rep(32'd100);
    #1; check("bp in_ready b0", 128'(in_ready), 128'(1'b1));
    tick();
    in_a = rep(32'd101);
    check("bp in_ready b1", 128'(in_ready), 128'(1'b1));
    tick();
    in_a = rep(32'd102);
    check("bp full in_ready", 128'(in_ready), 128'(1'b0));
    check("bp out_c b0", out_c, rep(32'd101));
    tick();
    check("bp hold1 in_ready", 128'(in_ready), 128'(1'b0));
    check("bp hold1 out_c", out_c, rep(32'd101));
    check("bp hold1 out_valid", 128'(out_valid), 128'(1'b1));
    tick();
    check("bp hold2 out_c", out_c, rep(32'd101));
    check("bp hold2 out_last", 128'(out_last), 128'(1'b0));
    out_ready = 1'b1;
    #1; check("bp release in_ready", 128'(in_ready), 128'(1'b1));
    tick();
    in_a = rep(32'd103);
    check("bp out_c b1", out_c, rep(32'd102));
    tick();
    in_valid = 1'b0;
    check("bp out_c b2", out_c, rep(32'd103));
    check("bp out_last b2", 128'(out_last), 128'(1'b0));
    tick();
    check("bp out_c b3", out_c, rep(32'd104));
    check("bp out_last b3", 128'(out_last), 128'(1'b1));
    tick();
    exp_mat++;
    check("bp drained", 128'(out_valid), 128'(1'b0));
    check("bp mat_count", 128'(mat_count), 128'(exp_mat));

    // Reset after two input beats discards the partial matrix.
    in_valid = 1'b1; in_a = rep(32'd1); in_b = rep(32'd1); mode = 2'b00;
    tick();
    tick();
    check("mid busy", 128'(busy), 128'(1'b1));
    in_valid = 1'b0; rst = 1'b1;
    #1;
    check("midrst out_valid", 128'(out_valid), 128'(1'b0));
    check("midrst in_ready", 128'(in_ready), 128'(1'b0));
    tick();
    check("midrst out_c", out_c, '0);
    check("midrst busy", 128'(busy), 128'(1'b0));
    rst = 1'b0;
    tick();
    check("midrst mat_count", 128'(mat_count), '0);
    check("midrst out_valid after", 128'(out_valid), 128'(1'b0));
    exp_mat = '0;
    send_matrix("afterrst", 2'b00, 2'b00, rep(32'd5), rep(32'd7), rep(32'd12), 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
